// File: rtl/reu_dma_seq_if.sv
// Signal bundle around the REU DMA sequencer: register-file start parameters,
// C64 bus mastering signals and the RDCMD/WRCMD/A/RDD request path to the SDRAM controller.
interface reu_dma_seq_if;
    logic        PHI2;
    logic        BA;
    logic        GO;
    logic [1:0]  TTYPE;
    logic [15:0] C64A0;
    logic [23:0] REUA0;
    logic [15:0] LEN0;
    logic        FIXC;
    logic        FIXR;
    logic [7:0]  RDD;
    logic [7:0]  CDI;
    logic        RDCMD;
    logic        WRCMD;
    logic [23:0] A;
    logic        nDMA;
    logic [15:0] CA;
    logic        CRW;
    logic        CDOE;
    logic [7:0]  CDO;
    logic        BUSY;
    logic        DONE;
    logic        VFAULT;
    logic [15:0] LEN;

    modport master (
        input  PHI2, BA, GO, TTYPE, C64A0, REUA0, LEN0, FIXC, FIXR, RDD, CDI,
        output RDCMD, WRCMD, A, nDMA, CA, CRW, CDOE, CDO, BUSY, DONE, VFAULT, LEN
    );

    modport slave (
        output PHI2, BA, GO, TTYPE, C64A0, REUA0, LEN0, FIXC, FIXR, RDD, CDI,
        input  RDCMD, WRCMD, A, nDMA, CA, CRW, CDOE, CDO, BUSY, DONE, VFAULT, LEN
    );
endinterface

// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: steps one byte per PHI2 slot, issuing SDRAM requests and
// mastering the C64 bus for stash, fetch, swap and verify transfers.
module reu_dma_seq (
    input  logic          C8M,
    input  logic          nRESET,
    reu_dma_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, ARM, XFER, SWR, SWW, FLUSH, FIN} state_t;

    localparam logic [1:0] T_STASH  = 2'd0;
    localparam logic [1:0] T_FETCH  = 2'd1;
    localparam logic [1:0] T_SWAP   = 2'd2;
    localparam logic [1:0] T_VERIFY = 2'd3;

    state_t      state_q, state_d;
    logic        phi2_n_q, phi2_s_q, phi2_p_q;
    logic        pf;
    logic [1:0]  ttype_q, ttype_d;
    logic        fixc_q, fixc_d;
    logic        fixr_q, fixr_d;
    logic [15:0] ca_q, ca_d;
    logic [15:0] len_q, len_d;
    logic [23:0] r_q, r_d;
    logic [23:0] a_q, a_d;
    logic [7:0]  tmp_q, tmp_d;
    logic        rdcmd_q, rdcmd_d;
    logic        wrcmd_q, wrcmd_d;
    logic        wait_q, wait_d;
    logic        vfault_q, vfault_d;
    logic        adv;
    logic        pend_new;
    logic        c64_wr;

    // PHI2 crosses in on the falling C8M edge, then is re-timed on the rising edge.
    always_ff @(negedge C8M or negedge nRESET) begin
        if (!nRESET) phi2_n_q <= 1'b0;
        else         phi2_n_q <= bus.PHI2;
    end

    always_ff @(posedge C8M or negedge nRESET) begin
        if (!nRESET) begin
            phi2_s_q <= 1'b0;
            phi2_p_q <= 1'b0;
            state_q  <= IDLE;
            ttype_q  <= 2'd0;
            fixc_q   <= 1'b0;
            fixr_q   <= 1'b0;
            ca_q     <= 16'd0;
            len_q    <= 16'd0;
            r_q      <= 24'd0;
            a_q      <= 24'd0;
            tmp_q    <= 8'd0;
            rdcmd_q  <= 1'b0;
            wrcmd_q  <= 1'b0;
            wait_q   <= 1'b0;
            vfault_q <= 1'b0;
        end else begin
            phi2_s_q <= phi2_n_q;
            phi2_p_q <= phi2_s_q;
            state_q  <= state_d;
            ttype_q  <= ttype_d;
            fixc_q   <= fixc_d;
            fixr_q   <= fixr_d;
            ca_q     <= ca_d;
            len_q    <= len_d;
            r_q      <= r_d;
            a_q      <= a_d;
            tmp_q    <= tmp_d;
            rdcmd_q  <= rdcmd_d;
            wrcmd_q  <= wrcmd_d;
            wait_q   <= wait_d;
            vfault_q <= vfault_d;
        end
    end

    assign pf = phi2_p_q & ~phi2_s_q;

    always_comb begin
        state_d  = state_q;
        ttype_d  = ttype_q;
        fixc_d   = fixc_q;
        fixr_d   = fixr_q;
        ca_d     = ca_q;
        len_d    = len_q;
        r_d      = r_q;
        a_d      = a_q;
        tmp_d    = tmp_q;
        rdcmd_d  = rdcmd_q;
        wrcmd_d  = wrcmd_q;
        wait_d   = wait_q;
        vfault_d = vfault_q;
        adv      = 1'b0;
        pend_new = 1'b0;

        // Closing side of the slot: act on the slot that is ending at this PF.
        case (state_q)
            IDLE: begin
                if (bus.GO) begin
                    state_d  = ARM;
                    ttype_d  = bus.TTYPE;
                    fixc_d   = bus.FIXC;
                    fixr_d   = bus.FIXR;
                    ca_d     = bus.C64A0;
                    r_d      = bus.REUA0;
                    a_d      = bus.REUA0;
                    len_d    = bus.LEN0;
                    wait_d   = 1'b0;
                    vfault_d = 1'b0;
                end
            end
            ARM: begin
                if (pf) state_d = (ttype_q == T_SWAP) ? SWR : XFER;
            end
            XFER: begin
                if (pf && !wait_q) begin
                    if (ttype_q == T_VERIFY && bus.RDD != bus.CDI) begin
                        vfault_d = 1'b1;
                        state_d  = FIN;
                    end else begin
                        adv      = 1'b1;
                        pend_new = (ttype_q == T_STASH);
                        if (len_q == 16'd1) state_d = (ttype_q == T_STASH) ? FLUSH : FIN;
                    end
                end
            end
            SWR: begin
                if (pf && !wait_q) begin
                    tmp_d   = bus.RDD;
                    state_d = SWW;
                end
            end
            SWW: begin
                if (pf && !wait_q) begin
                    adv     = 1'b1;
                    state_d = (len_q == 16'd1) ? FIN : SWR;
                end
            end
            FLUSH: begin
                if (pf) state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A length of 0 wraps to FFFF here, so 65536-byte transfers still end on 1.
        if (adv) begin
            if (!fixc_q) ca_d = ca_q + 16'd1;
            if (!fixr_q) r_d  = r_q + 24'd1;
            len_d = len_q - 16'd1;
        end

        // Opening side: the stash write of the byte just read rides in the next slot,
        // even when BA makes that slot a wait slot.
        if (pf && state_q != IDLE && state_q != FIN) begin
            wait_d  = ~bus.BA;
            rdcmd_d = bus.BA && ((state_d == XFER && ttype_q != T_STASH) || state_d == SWR);
            wrcmd_d = pend_new || (bus.BA && state_d == SWW);
            a_d     = pend_new ? r_q : r_d;
        end
    end

    assign c64_wr = !wait_q && ((state_q == XFER && ttype_q == T_FETCH) || state_q == SWW);

    assign bus.RDCMD  = rdcmd_q;
    assign bus.WRCMD  = wrcmd_q;
    assign bus.A      = a_q;
    assign bus.CA     = ca_q;
    assign bus.CRW    = ~c64_wr;
    assign bus.CDOE   = c64_wr & phi2_s_q;
    assign bus.CDO    = c64_wr ? ((state_q == SWW) ? tmp_q : bus.RDD) : 8'h00;
    assign bus.nDMA   = (state_q == IDLE) || (state_q == FIN);
    assign bus.BUSY   = (state_q != IDLE) && (state_q != FIN);
    assign bus.DONE   = (state_q == FIN);
    assign bus.VFAULT = vfault_q;
    assign bus.LEN    = len_q;
endmodule

// File: tb/tb_reu_dma_seq.sv
// Directed bench for reu_dma_seq with a simple C64 memory and SDRAM model on the PHI2 fall.
module tb_reu_dma_seq;
    logic C8M    = 1'b0;
    logic nRESET = 1'b0;

    reu_dma_seq_if bus ();

    reu_dma_seq dut (
        .C8M    (C8M),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 C8M = ~C8M;

    initial begin
        bus.PHI2 = 1'b1;
        #23;
        forever begin
            bus.PHI2 = 1'b0;
            #40;
            bus.PHI2 = 1'b1;
            #40;
        end
    end

    logic [7:0] c64mem [0:65535];
    logic [7:0] reumem [0:4095];
    logic [7:0] sd_latch = 8'h00;

    assign bus.RDD = reumem[bus.A[11:0]];
    assign bus.CDI = c64mem[bus.CA];

    int n_rd = 0, n_wr = 0, n_slot = 0, n_done = 0;
    logic [23:0] rd_log [$];
    logic [23:0] wr_log [$];

    // SDRAM latches the C64 bus at every PHI2 fall; a write slot stores the previous latch.
    always @(negedge bus.PHI2) begin
        if (!bus.nDMA) n_slot++;
        if (bus.RDCMD) begin
            n_rd++;
            rd_log.push_back(bus.A);
        end
        if (bus.WRCMD) begin
            n_wr++;
            wr_log.push_back(bus.A);
            reumem[bus.A[11:0]] = sd_latch;
        end
        sd_latch = bus.CRW ? c64mem[bus.CA] : bus.CDO;
        if (bus.CDOE && !bus.CRW) c64mem[bus.CA] = bus.CDO;
    end

    always @(negedge C8M) begin
        if (bus.DONE) n_done++;
    end

    int n_vec = 0, n_bad = 0;
    int b_rd, b_wr, b_slot, b_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_rdcmd"},  bus.RDCMD,  0);
        chk({tag, "_wrcmd"},  bus.WRCMD,  0);
        chk({tag, "_a"},      bus.A,      0);
        chk({tag, "_ndma"},   bus.nDMA,   1);
        chk({tag, "_ca"},     bus.CA,     0);
        chk({tag, "_crw"},    bus.CRW,    1);
        chk({tag, "_cdoe"},   bus.CDOE,   0);
        chk({tag, "_cdo"},    bus.CDO,    0);
        chk({tag, "_busy"},   bus.BUSY,   0);
        chk({tag, "_done"},   bus.DONE,   0);
        chk({tag, "_vfault"}, bus.VFAULT, 0);
        chk({tag, "_len"},    bus.LEN,    0);
    endtask

    task automatic snap();
        b_rd   = n_rd;
        b_wr   = n_wr;
        b_slot = n_slot;
        b_done = n_done;
    endtask

    task automatic start(input string tag, input logic [1:0] t, input logic [15:0] ca,
                         input logic [23:0] ra, input logic [15:0] len,
                         input logic fc, input logic fr);
        snap();
        @(negedge bus.PHI2);
        repeat (3) @(negedge C8M);
        bus.TTYPE = t;
        bus.C64A0 = ca;
        bus.REUA0 = ra;
        bus.LEN0  = len;
        bus.FIXC  = fc;
        bus.FIXR  = fr;
        bus.GO    = 1'b1;
        @(negedge C8M);
        bus.GO = 1'b0;
        chk({tag, "_go_ndma"}, bus.nDMA, 0);
        chk({tag, "_go_busy"}, bus.BUSY, 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge C8M);
            if (bus.DONE) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        repeat (4) @(negedge C8M);
        chk({tag, "_done_once"}, n_done - b_done, 1);
        chk({tag, "_end_ndma"}, bus.nDMA, 1);
        chk({tag, "_end_busy"}, bus.BUSY, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) c64mem[i] = 8'h00;
        for (int i = 0; i < 4096; i++)  reumem[i] = 8'h00;
        bus.BA    = 1'b1;
        bus.GO    = 1'b0;
        bus.TTYPE = 2'd0;
        bus.C64A0 = 16'h0000;
        bus.REUA0 = 24'h000000;
        bus.LEN0  = 16'h0000;
        bus.FIXC  = 1'b0;
        bus.FIXR  = 1'b0;

        repeat (3) @(negedge C8M);
        chk_rst("reset");
        nRESET = 1'b1;
        repeat (2) @(negedge C8M);

        // Fetch 3 bytes REU 0x100 -> C64 C000
        reumem[12'h100] = 8'h11;
        reumem[12'h101] = 8'h22;
        reumem[12'h102] = 8'h33;
        start("fetch", 2'd1, 16'hC000, 24'h000100, 16'd3, 1'b0, 1'b0);
        wait_done("fetch");
        chk("fetch_rd_slots", n_rd - b_rd, 3);
        chk("fetch_c000", c64mem[16'hC000], 8'h11);
        chk("fetch_c001", c64mem[16'hC001], 8'h22);
        chk("fetch_c002", c64mem[16'hC002], 8'h33);
        chk("fetch_len", bus.LEN, 0);
        chk("fetch_ca", bus.CA, 16'hC003);

        // Stash 2 bytes with fixed REU address
        c64mem[16'h2000] = 8'hA1;
        c64mem[16'h2001] = 8'hB2;
        start("stash", 2'd0, 16'h2000, 24'h000200, 16'd2, 1'b0, 1'b1);
        wait_done("stash");
        chk("stash_rd_slots", n_rd - b_rd, 0);
        chk("stash_wr_slots", n_wr - b_wr, 2);
        chk("stash_wr0_a", wr_log[b_wr], 24'h000200);
        chk("stash_wr1_a", wr_log[b_wr + 1], 24'h000200);
        chk("stash_slots_incl_arm", n_slot - b_slot, 4);
        chk("stash_ca", bus.CA, 16'h2002);
        chk("stash_reu200", reumem[12'h200], 8'hB2);

        // Swap 1 byte: REU AA <-> C64 55
        reumem[12'h300]  = 8'hAA;
        c64mem[16'h3000] = 8'h55;
        start("swap", 2'd2, 16'h3000, 24'h000300, 16'd1, 1'b0, 1'b0);
        wait_done("swap");
        chk("swap_rd_slots", n_rd - b_rd, 1);
        chk("swap_wr_slots", n_wr - b_wr, 1);
        chk("swap_rd_a", rd_log[b_rd], 24'h000300);
        chk("swap_wr_a", wr_log[b_wr], 24'h000300);
        chk("swap_c64", c64mem[16'h3000], 8'hAA);
        chk("swap_reu", reumem[12'h300], 8'h55);
        chk("swap_slots_incl_arm", n_slot - b_slot, 3);
        chk("swap_ca", bus.CA, 16'h3001);

        // Verify 4 bytes, mismatch on the second
        reumem[12'h400] = 8'h10; c64mem[16'h4000] = 8'h10;
        reumem[12'h401] = 8'h20; c64mem[16'h4001] = 8'h99;
        reumem[12'h402] = 8'h30; c64mem[16'h4002] = 8'h30;
        reumem[12'h403] = 8'h40; c64mem[16'h4003] = 8'h40;
        start("verify", 2'd3, 16'h4000, 24'h000400, 16'd4, 1'b0, 1'b0);
        wait_done("verify");
        chk("verify_vfault", bus.VFAULT, 1);
        chk("verify_len", bus.LEN, 3);
        chk("verify_ca", bus.CA, 16'h4001);
        chk("verify_rd_slots", n_rd - b_rd, 2);
        chk("verify_slots_incl_arm", n_slot - b_slot, 3);

        // Stash 3 bytes with BA low for two slots after the first byte
        c64mem[16'h5000] = 8'hC1;
        c64mem[16'h5001] = 8'hC2;
        c64mem[16'h5002] = 8'hC3;
        start("bawait", 2'd0, 16'h5000, 24'h000500, 16'd3, 1'b0, 1'b0);
        chk("bawait_vfault_clr", bus.VFAULT, 0);
        @(negedge bus.PHI2);
        @(negedge bus.PHI2);
        bus.BA = 1'b0;
        @(negedge bus.PHI2);
        chk("bawait_w1_wrcmd", bus.WRCMD, 1);
        chk("bawait_w1_rdcmd", bus.RDCMD, 0);
        chk("bawait_w1_a", bus.A, 24'h000500);
        @(negedge bus.PHI2);
        chk("bawait_w2_wrcmd", bus.WRCMD, 0);
        chk("bawait_w2_ca", bus.CA, 16'h5001);
        chk("bawait_w2_len", bus.LEN, 2);
        bus.BA = 1'b1;
        wait_done("bawait");
        chk("bawait_wr_slots", n_wr - b_wr, 3);
        chk("bawait_slots_incl_arm", n_slot - b_slot, 7);
        chk("bawait_reu500", reumem[12'h500], 8'hC1);
        chk("bawait_reu501", reumem[12'h501], 8'hC2);
        chk("bawait_reu502", reumem[12'h502], 8'hC3);
        chk("bawait_ca", bus.CA, 16'h5003);

        // 65536-byte fetch from FFFFFF, reset mid-run
        reumem[12'hFFF] = 8'h5A;
        start("big", 2'd1, 16'h6000, 24'hFFFFFF, 16'd0, 1'b0, 1'b0);
        chk("big_len_load", bus.LEN, 0);
        @(negedge bus.PHI2);
        @(negedge bus.PHI2);
        repeat (4) @(negedge C8M);
        chk("big_len_ffff", bus.LEN, 16'hFFFF);
        chk("big_a_wrap", bus.A, 24'h000000);
        chk("big_ca", bus.CA, 16'h6001);
        chk("big_c6000", c64mem[16'h6000], 8'h5A);
        chk("big_rdcmd", bus.RDCMD, 1);
        #3;
        nRESET = 1'b0;
        #1;
        chk_rst("midrst");
        @(negedge C8M);
        nRESET = 1'b1;
        repeat (20) @(negedge C8M);
        chk("postrst_busy", bus.BUSY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
